// File: rtl/md_pkg.sv
// md_pkg: shared md_op encodings, op width and default latencies for the multiply/divide unit and its decoder
package md_pkg;
  localparam int MD_OP_W = 3;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} md_state_e;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/multu/div/divu on latched operands; op,x,y in -> res {hi,lo} and div_zero out
module md_arith
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        x,
  input  logic [31:0]        y,
  output logic [63:0]        res,
  output logic               div_zero
);
  logic sgn;
  logic [63:0] prod;
  logic [31:0] ax, ay, dy, q, r;
  always_comb begin
    sgn = op == MD_MULT || op == MD_DIV;
    prod = {{32{sgn & x[31]}}, x} * {{32{sgn & y[31]}}, y};
    ax = sgn && x[31] ? -x : x;
    ay = sgn && y[31] ? -y : y;
    div_zero = y == '0 && (op == MD_DIV || op == MD_DIVU);
    dy = ay == '0 ? 32'd1 : ay;
    q = ax / dy;
    r = ax % dy;
    res = op == MD_MULT || op == MD_MULTU ? prod :
          {sgn && x[31] ? -r : r, sgn && (x[31] ^ y[31]) ? -q : q};
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: fixed-latency mult/div scheduler owning HI/LO; start/md_op/a/b/id_md_use in -> busy, stall, hi, lo out
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  input  logic               id_md_use,
  output logic               busy,
  output logic               stall,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);
  md_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [MD_OP_W-1:0] op_q;
  logic [31:0] a_q, b_q, hi_n, lo_n;
  logic [63:0] res;
  logic div_zero, md_start, ld;
  md_arith u_arith (.op(op_q), .x(a_q), .y(b_q), .res(res), .div_zero(div_zero));
  assign md_start = start && md_op <= MD_DIVU;
  assign busy = state == S_RUN;
  assign stall = id_md_use & (busy | md_start);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ld = 1'b0;
    hi_n = hi;
    lo_n = lo;
    if (state == S_IDLE) begin
      if (md_start) begin
        state_n = S_RUN;
        ld = 1'b1;
        cnt_n = md_op == MD_DIV || md_op == MD_DIVU ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
      end
      hi_n = start && md_op == MD_MTHI ? a : hi;
      lo_n = start && md_op == MD_MTLO ? a : lo;
    end else begin
      cnt_n = cnt - 4'd1;
      if (cnt == '0) begin
        state_n = S_IDLE;
        cnt_n = '0;
        {hi_n, lo_n} = div_zero ? {hi, lo} : res;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hi <= hi_n;
      lo <= lo_n;
      if (ld) begin
        op_q <= md_op;
        a_q <= a;
        b_q <= b;
      end
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and random checks of md_sched against a plain-arithmetic HI/LO model
module tb_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 1'b0, reset, start, id_md_use, busy, stall;
  logic [2:0] md_op;
  logic [31:0] a, b, hi, lo;
  logic [31:0] m_hi, m_lo;
  int n_chk, n_fail;
  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .id_md_use(id_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    if (op == 0) begin
      p = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (op == 1) begin
      up = ux * uy;
      m_hi = up[63:32];
      m_lo = up[31:0];
    end else if ((op == 2 || op == 3) && y != 0) begin
      m_lo = op == 2 ? 32'(sx / sy) : 32'(ux / uy);
      m_hi = op == 2 ? 32'(sx % sy) : 32'(ux % uy);
    end else if (op == 4) m_hi = x;
    else if (op == 5) m_lo = x;
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic use_md, input logic ign);
    int n;
    start = 1'b1;
    md_op = op;
    a = x;
    b = y;
    id_md_use = use_md;
    #1 chk("stall_start", 32'(stall), 32'(use_md && op <= 3));
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    if (op <= 3) begin
      n = op >= 2 ? DC : MC;
      for (int k = 0; k < n; k++) begin
        if (ign && k == 1) begin
          start = 1'b1;
          md_op = 3'($urandom_range(0, 5));
        end
        if (k == 2) start = 1'b0;
        #1;
        chk("busy_run", 32'(busy), 32'd1);
        chk("stall_run", 32'(stall), 32'(use_md));
        chk("hi_hold", hi, m_hi);
        chk("lo_hold", lo, m_lo);
        tick();
      end
      start = 1'b0;
    end
    model(op, x, y);
    #1;
    chk("busy_done", 32'(busy), 32'd0);
    chk("stall_done", 32'(stall), 32'd0);
    chk("hi_res", hi, m_hi);
    chk("lo_res", lo, m_lo);
  endtask
  initial begin
    logic [2:0] rop;
    logic [31:0] rx, ry;
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    start = 1'b0;
    md_op = '0;
    a = '0;
    b = '0;
    id_md_use = 1'b1;
    m_hi = '0;
    m_lo = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    chk("mult_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_lo_const", lo, 32'hFFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    chk("multu_hi_const", hi, 32'h00000001);
    chk("multu_lo_const", lo, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    chk("div_hi_const", hi, 32'hFFFFFFFF);
    chk("div_lo_const", lo, 32'hFFFFFFFD);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    chk("divu_hi_const", hi, 32'h00000001);
    chk("divu_lo_const", lo, 32'h7FFFFFFC);
    run_op(3'd4, 32'h12345678, 32'd0, 1'b1, 1'b0);
    chk("mthi_const", hi, 32'h12345678);
    run_op(3'd3, 32'h55555555, 32'd0, 1'b1, 1'b0);
    chk("divz_hi_const", hi, 32'h12345678);
    chk("divz_lo_const", lo, 32'h7FFFFFFC);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    chk("ovf_hi_const", hi, 32'h00000000);
    chk("ovf_lo_const", lo, 32'h80000000);
    run_op(3'd5, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    run_op(3'd6, 32'hDEADBEEF, 32'd1, 1'b1, 1'b0);
    run_op(3'd7, 32'hDEADBEEF, 32'd1, 1'b1, 1'b0);
    start = 1'b1;
    md_op = 3'd0;
    a = 32'd7;
    b = 32'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    tick();
    tick();
    tick();
    chk("abort_nocommit_hi", hi, 32'd0);
    chk("abort_nocommit_lo", lo, 32'd0);
    chk("abort_nobusy", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rx = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      ry = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom);
      run_op(rop, rx, ry, 1'($urandom), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
